// File: rtl/cam_cfg_sequencer.sv
// Camera configuration sequencer: walks a register ROM and issues each {reg, val}
// entry as an SCCB write, handling delay/end markers and bounded NACK retries.
module cam_cfg_sequencer #(
  parameter int ROM_AW       = 8,
  parameter int DELAY_CYCLES = 2500000,
  parameter int MAX_RETRY    = 3
) (
  input  logic              i_sysclk,
  input  logic              i_rst,
  input  logic              i_cfg_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_sccb_start,
  output logic [7:0]        o_sccb_reg,
  output logic [7:0]        o_sccb_val,
  input  logic              i_sccb_ready,
  input  logic              i_sccb_done,
  input  logic              i_sccb_nack,
  output logic              o_cfg_done,
  output logic              o_busy,
  output logic              o_err
);

  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [DW-1:0]     LP_DELAY_LOAD = DW'(DELAY_CYCLES - 1);
  localparam logic [RW-1:0]     LP_MAX_RETRY  = RW'(MAX_RETRY);
  localparam logic [ROM_AW-1:0] LP_LAST_ADDR  = '1;
  localparam logic [15:0]       LP_END_MARK   = 16'hFFFF;
  localparam logic [15:0]       LP_DELAY_MARK = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [7:0]        r_reg;
  logic [7:0]        r_val;
  logic [RW-1:0]     r_retry;
  logic [DW-1:0]     r_delay;

  logic w_last;
  logic w_retry_max;
  logic w_delay_zero;

  assign w_last       = (r_rom_addr == LP_LAST_ADDR);
  assign w_retry_max  = (r_retry == LP_MAX_RETRY);
  assign w_delay_zero = (r_delay == '0);

  always_ff @(posedge i_sysclk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The last ROM address acts as an implicit end marker so the address never wraps.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_cfg_start) w_next = S_READ;
      end
      S_READ:   w_next = S_DECODE;
      S_DECODE: begin
        if (i_rom_data == LP_END_MARK)        w_next = S_DONE;
        else if (i_rom_data == LP_DELAY_MARK) w_next = S_DELAY;
        else                                  w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_sccb_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_sccb_done) begin
          if (!i_sccb_nack)     w_next = w_last ? S_DONE : S_READ;
          else if (w_retry_max) w_next = S_ERROR;
          else                  w_next = S_ISSUE;
        end
      end
      S_DELAY: begin
        if (w_delay_zero) w_next = w_last ? S_DONE : S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk or posedge i_rst) begin
    if (i_rst) begin
      r_rom_addr <= '0;
      r_reg      <= '0;
      r_val      <= '0;
      r_retry    <= '0;
      r_delay    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_cfg_start) begin
            r_rom_addr <= '0;
            r_retry    <= '0;
          end
        end
        S_DECODE: begin
          if (i_rom_data == LP_DELAY_MARK) begin
            r_delay <= LP_DELAY_LOAD;
          end else if (i_rom_data != LP_END_MARK) begin
            r_reg <= i_rom_data[15:8];
            r_val <= i_rom_data[7:0];
          end
        end
        S_WAIT: begin
          if (i_sccb_done) begin
            if (!i_sccb_nack) begin
              r_retry <= '0;
              if (!w_last) r_rom_addr <= r_rom_addr + 1'b1;
            end else if (!w_retry_max) begin
              r_retry <= r_retry + 1'b1;
            end
          end
        end
        S_DELAY: begin
          if (w_delay_zero) begin
            if (!w_last) r_rom_addr <= r_rom_addr + 1'b1;
          end else begin
            r_delay <= r_delay - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    o_rom_addr   = r_rom_addr;
    o_sccb_reg   = r_reg;
    o_sccb_val   = r_val;
    o_sccb_start = (r_state == S_ISSUE) && i_sccb_ready;
    o_cfg_done   = (r_state == S_DONE);
    o_err        = (r_state == S_ERROR);
    o_busy       = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Self-checking bench for cam_cfg_sequencer: ROM + SCCB master models, a write
// scoreboard, a vector table of configuration passes and hand-written corner cases.
module tb_cam_cfg_sequencer;

  localparam int ROM_AW       = 3;
  localparam int DELAY_CYCLES = 16;
  localparam int MAX_RETRY    = 3;
  localparam int ACK_DELAY    = 10;
  localparam int NUM_VECS     = 8;
  localparam int BOUND        = 3000;

  logic              i_sysclk;
  logic              i_rst;
  logic              i_cfg_start;
  logic [ROM_AW-1:0] o_rom_addr;
  logic [15:0]       i_rom_data;
  logic              o_sccb_start;
  logic [7:0]        o_sccb_reg;
  logic [7:0]        o_sccb_val;
  logic              i_sccb_ready;
  logic              i_sccb_done;
  logic              i_sccb_nack;
  logic              o_cfg_done;
  logic              o_busy;
  logic              o_err;

  cam_cfg_sequencer #(
    .ROM_AW(ROM_AW), .DELAY_CYCLES(DELAY_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_sysclk(i_sysclk), .i_rst(i_rst), .i_cfg_start(i_cfg_start),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_sccb_start(o_sccb_start), .o_sccb_reg(o_sccb_reg), .o_sccb_val(o_sccb_val),
    .i_sccb_ready(i_sccb_ready), .i_sccb_done(i_sccb_done), .i_sccb_nack(i_sccb_nack),
    .o_cfg_done(o_cfg_done), .o_busy(o_busy), .o_err(o_err)
  );

  typedef struct {
    string       name;
    logic [15:0] rom [8];
    int          nacks;
    bit          expDone;
    bit          expErr;
    int          expStarts;
  } vec_t;

  vec_t        vecs [NUM_VECS];
  logic [15:0] rom [8];
  logic [15:0] sbQ [$];
  int          checks = 0;
  int          errors = 0;
  int          startCount = 0;
  int          nackRemaining = 0;
  bit          holdOff = 0;
  bit          inFlight = 0;
  bit          justStarted = 0;
  bit          curNack = 0;
  bit          busyQ = 0;
  int          ackTimer = 0;

  initial i_sysclk = 1'b0;
  always #5 i_sysclk = ~i_sysclk;

  always @(posedge i_sysclk) i_rom_data <= rom[o_rom_addr];

  // Ready drops one edge after a start is seen so the DUT still samples it high.
  always @(posedge i_sysclk) busyQ <= inFlight;
  assign i_sccb_ready = !busyQ && !holdOff;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // SCCB master model: scores each write request and answers with done/nack later.
  always @(negedge i_sysclk) begin
    i_sccb_done = 1'b0;
    i_sccb_nack = 1'b0;
    if (i_rst) begin
      inFlight    = 1'b0;
      justStarted = 1'b0;
    end else if (inFlight) begin
      if (justStarted) begin
        checkOutput("start_width", {31'd0, o_sccb_start}, 32'd0);
        justStarted = 1'b0;
      end
      if (ackTimer == 0) begin
        i_sccb_done = 1'b1;
        i_sccb_nack = curNack;
        inFlight    = 1'b0;
      end else begin
        ackTimer--;
      end
    end else if (o_sccb_start) begin
      startCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_write", {16'd0, o_sccb_reg, o_sccb_val}, 32'hDEAD);
      end else begin
        checkOutput("write_regval", {16'd0, o_sccb_reg, o_sccb_val}, {16'd0, sbQ.pop_front()});
      end
      inFlight    = 1'b1;
      justStarted = 1'b1;
      ackTimer    = ACK_DELAY - 1;
      curNack     = (nackRemaining > 0);
      if (curNack) nackRemaining--;
    end
  end

  // Reference walk of the ROM: queue every write attempt the sequencer should make.
  task automatic pushExpected(input int nacks);
    int left = nacks;
    for (int a = 0; a < 8; a++) begin
      int tries = 0;
      if (rom[a] == 16'hFFFF) return;
      if (rom[a] == 16'hFFF0) continue;
      forever begin
        sbQ.push_back(rom[a]);
        tries++;
        if (left > 0) begin
          left--;
          if (tries > MAX_RETRY) return;
        end else begin
          break;
        end
      end
    end
  endtask

  task automatic pulseStart();
    @(negedge i_sysclk);
    i_cfg_start = 1'b1;
    @(negedge i_sysclk);
    i_cfg_start = 1'b0;
  endtask

  task automatic waitFinish(input string tag);
    int n = 0;
    while (!(o_cfg_done || o_err) && n < BOUND) begin
      @(negedge i_sysclk);
      n++;
    end
    checkOutput({tag, "_finished"}, {31'd0, (o_cfg_done || o_err)}, 32'd1);
    repeat (2) @(negedge i_sysclk);
  endtask

  task automatic checkEnd(input string tag, input bit expDone, input bit expErr, input int expStarts);
    checkOutput({tag, "_done"}, {31'd0, o_cfg_done}, {31'd0, expDone});
    checkOutput({tag, "_err"}, {31'd0, o_err}, {31'd0, expErr});
    checkOutput({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    checkOutput({tag, "_starts"}, startCount, expStarts);
    checkOutput({tag, "_sb_empty"}, sbQ.size(), 0);
  endtask

  task automatic applyStimulus(input int idx);
    rom           = vecs[idx].rom;
    nackRemaining = vecs[idx].nacks;
    startCount    = 0;
    sbQ.delete();
    pushExpected(vecs[idx].nacks);
    pulseStart();
    waitFinish(vecs[idx].name);
    checkEnd(vecs[idx].name, vecs[idx].expDone, vecs[idx].expErr, vecs[idx].expStarts);
  endtask

  initial begin
    int cyc;
    int seen;
    vecs[0] = '{"basic",     '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0,    1'b1, 1'b0, 2};
    vecs[1] = '{"nack2",     '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 2,    1'b1, 1'b0, 4};
    vecs[2] = '{"nack_all",  '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1000, 1'b0, 1'b1, 4};
    vecs[3] = '{"rerun",     '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0,    1'b1, 1'b0, 2};
    vecs[4] = '{"wrap",      '{16'h0100, 16'h0201, 16'h0302, 16'h0403, 16'h0504, 16'h0605, 16'h0706, 16'h0807}, 0,    1'b1, 1'b0, 8};
    vecs[5] = '{"mid_delay", '{16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0,    1'b1, 1'b0, 2};
    vecs[6] = '{"empty",     '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0,    1'b1, 1'b0, 0};
    vecs[7] = '{"last_try",  '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 3,    1'b1, 1'b0, 5};

    for (int a = 0; a < 8; a++) rom[a] = 16'hFFFF;
    i_rst       = 1'b1;
    i_cfg_start = 1'b0;
    repeat (3) @(negedge i_sysclk);
    checkOutput("reset_outputs",
                {13'd0, o_rom_addr, o_sccb_start, o_sccb_reg, o_sccb_val, o_cfg_done, o_busy, o_err}, 32'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_sysclk);

    $display("[TB] running vector table");
    for (int v = 0; v < NUM_VECS; v++) applyStimulus(v);

    // Delay marker first: start must appear exactly DELAY_CYCLES + 4 cycles after start is sampled.
    $display("[TB] delay timing");
    rom = '{16'hFFF0, 16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    startCount = 0;
    sbQ.delete();
    pushExpected(0);
    @(negedge i_sysclk);
    i_cfg_start = 1'b1;
    @(posedge i_sysclk);
    #1 i_cfg_start = 1'b0;
    cyc = 0;
    forever begin
      @(negedge i_sysclk);
      if (o_sccb_start || cyc >= 200) break;
      cyc++;
    end
    checkOutput("delay_latency", cyc, DELAY_CYCLES + 4);
    waitFinish("delay");
    checkEnd("delay", 1'b1, 1'b0, 1);

    // Ready held low in ISSUE, with a stray start pulse that must be ignored.
    $display("[TB] ready hold");
    rom = vecs[0].rom;
    startCount = 0;
    sbQ.delete();
    pushExpected(0);
    holdOff = 1'b1;
    pulseStart();
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge i_sysclk);
      if (o_sccb_start) seen++;
      if (c == 20) i_cfg_start = 1'b1;
      if (c == 21) i_cfg_start = 1'b0;
    end
    checkOutput("hold_no_start", seen, 0);
    checkOutput("hold_busy", {31'd0, o_busy}, 32'd1);
    checkOutput("hold_regval", {16'd0, o_sccb_reg, o_sccb_val}, 32'h1280);
    holdOff = 1'b0;
    waitFinish("hold");
    checkEnd("hold", 1'b1, 1'b0, 2);

    // Async reset while a write is outstanding, then a clean pass from address 0.
    $display("[TB] reset in wait");
    startCount = 0;
    sbQ.delete();
    pushExpected(0);
    pulseStart();
    cyc = 0;
    while (!inFlight && cyc < 200) begin
      @(negedge i_sysclk);
      cyc++;
    end
    checkOutput("reached_wait", {31'd0, inFlight}, 32'd1);
    repeat (3) @(negedge i_sysclk);
    @(posedge i_sysclk);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs",
                {13'd0, o_rom_addr, o_sccb_start, o_sccb_reg, o_sccb_val, o_cfg_done, o_busy, o_err}, 32'd0);
    repeat (2) @(negedge i_sysclk);
    i_rst = 1'b0;
    sbQ.delete();
    @(negedge i_sysclk);
    applyStimulus(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_cfg_sequencer.md
Name: cam_cfg_sequencer

Overview:
Walks a synchronous register ROM of {reg_addr, reg_data} entries and issues each entry as a write transaction to the SCCB master. It supports in-ROM delay and end markers, and retries NACKed writes a bounded number of times. Its start input is the system controller's cfg_start pulse, and its o_cfg_done output feeds the system controller's cfg_done input, which gates pipeline flush release.

Parameters:
ROM_AW, 8, ROM address width; the ROM holds 2^ROM_AW 16-bit entries.
DELAY_CYCLES, 2500000, i_sysclk cycles waited on a delay marker (default is 20 ms at 125 MHz).
MAX_RETRY, 3, retries per entry after a NACK before the block enters the error state.

Ports:
i_sysclk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_cfg_start  in  1  single-cycle pulse; starts a configuration pass
o_rom_addr  out  ROM_AW  ROM read address
i_rom_data  in  16  ROM entry {reg[15:8], val[7:0]}, valid 1 cycle after o_rom_addr
o_sccb_start  out  1  single-cycle write request to the SCCB master
o_sccb_reg  out  8  register address for the write
o_sccb_val  out  8  register data for the write
i_sccb_ready  in  1  SCCB master is idle and can accept o_sccb_start
i_sccb_done  in  1  single-cycle pulse: write finished
i_sccb_nack  in  1  qualified by i_sccb_done: slave NACKed
o_cfg_done  out  1  level; high once a pass completes, cleared on a new start
o_busy  out  1  level; high in every state except IDLE, DONE and ERROR
o_err  out  1  level; retries exhausted, sticky until the next start

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, o_rom_addr=0, o_sccb_start=0, o_sccb_reg=0, o_sccb_val=0, o_cfg_done=0, o_busy=0, o_err=0, retry counter=0, delay counter=0.
- States: IDLE, READ, DECODE, ISSUE, WAIT, DELAY, DONE, ERROR.
- IDLE/DONE/ERROR + i_cfg_start:
  - o_rom_addr<=0, o_cfg_done<=0, o_err<=0, retry<=0, next state READ.
  - i_cfg_start is ignored in all other states; a restart mid-pass is not possible.
- READ: one cycle for ROM latency -> DECODE.
- DECODE, based on i_rom_data:
  - 16'hFFFF (end marker) -> DONE.
  - 16'hFFF0 (delay marker) -> load delay counter with DELAY_CYCLES-1 -> DELAY.
  - Any other value -> latch reg/val into o_sccb_reg/o_sccb_val -> ISSUE.
- ISSUE: wait for i_sccb_ready=1, then assert o_sccb_start for exactly one cycle -> WAIT. o_sccb_reg/o_sccb_val stay stable from ISSUE until leaving WAIT.
- WAIT, on i_sccb_done:
  - nack=0: retry<=0, o_rom_addr+1 -> READ.
  - nack=1 and retry<MAX_RETRY: retry+1 -> ISSUE with the same entry.
  - nack=1 and retry=MAX_RETRY: -> ERROR.
  - Retry count is per entry; MAX_RETRY=3 means 4 total attempts.
- DELAY: counter decrements each cycle; at 0, o_rom_addr+1 -> READ. The delay is exactly DELAY_CYCLES cycles in DELAY.
- DONE: o_cfg_done=1. ERROR: o_err=1, o_cfg_done=0. Both are held until i_cfg_start or reset.
- Address wrap: if the last ROM entry is written without an end marker, o_rom_addr would wrap to 0. The block instead treats the last address as an implicit end and goes -> DONE after that write completes.
- i_sccb_done outside WAIT is ignored. i_sccb_done arriving in the same cycle as o_sccb_start is not legal from the master.
- Reset mid-transaction aborts immediately with all outputs at their reset values. The SCCB master is reset by the same i_rst.
- Throughput: from i_sccb_done (ack) to the next o_sccb_start is at least 3 cycles (READ, DECODE, ISSUE).

Test Plan:
1. ROM = {0x1280, 0x1101, FFFF}, SCCB model ready, ack after 10 cycles. Pulse start -> two writes (reg 0x12 val 0x80, then reg 0x11 val 0x01), then o_cfg_done=1, o_busy=0. o_sccb_start is high for exactly 1 cycle per write.
2. ROM = {FFF0, 0x1280, FFFF}, DELAY_CYCLES=16 -> first o_sccb_start occurs 16 cycles in DELAY plus the READ/DECODE/ISSUE overhead after start. Exact cycle count is checked.
3. NACK the first 2 attempts of entry 0x1280, ack the third -> 3 o_sccb_start pulses, all with reg 0x12 val 0x80, then normal completion.
4. NACK every attempt, MAX_RETRY=3 -> exactly 4 starts, then o_err=1, o_cfg_done=0, o_busy=0. A new start clears o_err and reruns from address 0.
5. Assert i_rst during WAIT -> all outputs go to 0 asynchronously, before the next clock edge. Pulse start after reset release -> pass restarts at address 0.
6. Hold i_sccb_ready=0 for 50 cycles in ISSUE -> no start is issued until ready rises. i_cfg_start pulses during a pass have no effect.
